// File: rtl/square_wave_period_meter.sv
// Measures edge-to-edge spacing of an asynchronous square wave in clk cycles.
// Reports half-period, full period, equivalent divider setting and a stall timeout.
module square_wave_period_meter #(
  parameter int counter_bits = 16,
  parameter int sync_stages  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sq_in,
  output logic [counter_bits-1:0] half_period,
  output logic [counter_bits:0]   period,
  output logic [counter_bits-1:0] divider_est,
  output logic                    last_rising,
  output logic                    valid,
  output logic                    pair_ok,
  output logic                    timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [counter_bits-1:0] CNT_MAX = {counter_bits{1'b1}};
  localparam logic [counter_bits-1:0] CNT_ONE = counter_bits'(1);

  state_t                  state_q;
  logic [sync_stages-1:0]  sync_q;
  logic                    dly_q;
  logic [counter_bits-1:0] cnt_q;
  logic [counter_bits-1:0] prev_half_q;
  logic                    have_prev_q;
  logic [counter_bits-1:0] half_period_q;
  logic [counter_bits:0]   period_q;
  logic                    last_rising_q;
  logic                    valid_q;
  logic                    pair_ok_q;
  logic                    timeout_q;

  logic                    sync_out;
  logic                    edge_det;
  logic                    cnt_at_max;
  logic [counter_bits-1:0] cnt_d;
  logic [counter_bits:0]   period_d;
  logic [counter_bits-1:0] half_m1;

  assign sync_out   = sync_q[sync_stages-1];
  assign edge_det   = sync_out ^ dly_q;
  assign cnt_at_max = (cnt_q == CNT_MAX);
  assign cnt_d      = cnt_q + CNT_ONE;
  assign period_d   = {1'b0, prev_half_q} + {1'b0, cnt_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      dly_q         <= 1'b0;
      cnt_q         <= '0;
      prev_half_q   <= '0;
      have_prev_q   <= 1'b0;
      half_period_q <= '0;
      period_q      <= '0;
      last_rising_q <= 1'b0;
      valid_q       <= 1'b0;
      pair_ok_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[sync_stages-2:0], sq_in};
      dly_q   <= sync_out;
      valid_q <= 1'b0;
      if (!enable) begin
        // Dropping enable discards any in-flight edge and forgets the pairing.
        state_q     <= IDLE;
        cnt_q       <= '0;
        pair_ok_q   <= 1'b0;
        have_prev_q <= 1'b0;
        prev_half_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q   <= ACQUIRE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
          ACQUIRE: begin
            if (edge_det) begin
              cnt_q   <= CNT_ONE;
              state_q <= MEASURE;
            end else if (cnt_at_max) begin
              timeout_q   <= 1'b1;
              cnt_q       <= '0;
              pair_ok_q   <= 1'b0;
              have_prev_q <= 1'b0;
              prev_half_q <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              half_period_q <= cnt_q;
              prev_half_q   <= cnt_q;
              have_prev_q   <= 1'b1;
              last_rising_q <= sync_out;
              valid_q       <= 1'b1;
              timeout_q     <= 1'b0;
              cnt_q         <= CNT_ONE;
              if (have_prev_q) begin
                period_q  <= period_d;
                pair_ok_q <= 1'b1;
              end
            end else if (cnt_at_max) begin
              timeout_q   <= 1'b1;
              cnt_q       <= '0;
              pair_ok_q   <= 1'b0;
              have_prev_q <= 1'b0;
              prev_half_q <= '0;
              state_q     <= ACQUIRE;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign half_m1     = half_period_q - CNT_ONE;
  assign divider_est = (half_period_q == '0) ? '0 : {half_m1[counter_bits-2:0], 1'b0};

  assign half_period = half_period_q;
  assign period      = period_q;
  assign last_rising = last_rising_q;
  assign valid       = valid_q;
  assign pair_ok     = pair_ok_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Directed bench for square_wave_period_meter: a 16-bit instance and a 4-bit
// instance share the same stimulus; the 4-bit one exercises the stall timeout.
module tb_square_wave_period_meter;

  logic clk;
  logic reset;
  logic enable;
  logic sq_in;

  logic [15:0] hp, div;
  logic [16:0] per;
  logic        lr, vld, pok, to;

  logic [3:0]  hp4, div4;
  logic [4:0]  per4;
  logic        lr4, vld4, pok4, to4;

  int checks = 0;
  int errors = 0;

  int q_half[$], q_per[$], q_pair[$], q_rise[$], q_div[$], q_to[$];
  int q4_half[$], q4_div[$], q4_to[$];

  square_wave_period_meter #(.counter_bits(16), .sync_stages(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sq_in(sq_in),
    .half_period(hp), .period(per), .divider_est(div), .last_rising(lr),
    .valid(vld), .pair_ok(pok), .timeout(to)
  );

  square_wave_period_meter #(.counter_bits(4), .sync_stages(2)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .sq_in(sq_in),
    .half_period(hp4), .period(per4), .divider_est(div4), .last_rising(lr4),
    .valid(vld4), .pair_ok(pok4), .timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_q();
    q_half.delete(); q_per.delete(); q_pair.delete(); q_rise.delete();
    q_div.delete(); q_to.delete();
    q4_half.delete(); q4_div.delete(); q4_to.delete();
  endtask

  // Advance n cycles, recording every valid sample of both instances.
  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (vld) begin
        q_half.push_back(int'(hp)); q_per.push_back(int'(per));
        q_pair.push_back(int'(pok)); q_rise.push_back(int'(lr));
        q_div.push_back(int'(div)); q_to.push_back(int'(to));
      end
      if (vld4) begin
        q4_half.push_back(int'(hp4)); q4_div.push_back(int'(div4));
        q4_to.push_back(int'(to4));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; sq_in = 1'b0;
    run_cycles(3);
    reset = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({hp, per, div, lr, vld, pok, to} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got hp=%0d per=%0d div=%0d lr=%0b v=%0b pok=%0b to=%0b, want all 0",
               hp, per, div, lr, vld, pok, to);
    end
    checks++;
    if ({hp4, per4, div4, lr4, vld4, pok4, to4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs4: got hp=%0d per=%0d to=%0b, want all 0", hp4, per4, to4);
    end
    sq_in = 1'b1; run_cycles(8);
    sq_in = 1'b0; run_cycles(8);
    checks++;
    if (q_half.size() != 0 || q4_half.size() != 0 || hp !== 16'd0) begin
      errors++;
      $display("FAIL idle_no_valid: got %0d/%0d valids hp=%0d, want 0/0 hp=0",
               q_half.size(), q4_half.size(), hp);
    end
  endtask

  task automatic test_symmetric();
    do_reset();
    enable = 1'b1;
    sq_in = 1'b1; run_cycles(5);
    sq_in = 1'b0; run_cycles(5);
    sq_in = 1'b1; run_cycles(5);
    sq_in = 1'b0; run_cycles(6);
    checks++;
    if (q_half.size() != 3) begin
      errors++;
      $display("FAIL sym_valid_count: got %0d, want 3", q_half.size());
    end else begin
      checks++;
      if (q_half[0] != 5 || q_div[0] != 8 || q_pair[0] != 0) begin
        errors++;
        $display("FAIL sym_first: got hp=%0d div=%0d pok=%0d, want 5 8 0", q_half[0], q_div[0], q_pair[0]);
      end
      checks++;
      if (q_per[1] != 10 || q_pair[1] != 1 || q_half[1] != 5) begin
        errors++;
        $display("FAIL sym_second: got per=%0d pok=%0d hp=%0d, want 10 1 5", q_per[1], q_pair[1], q_half[1]);
      end
      checks++;
      if (q_rise[0] != 0 || q_rise[1] != 1 || q_rise[2] != 0) begin
        errors++;
        $display("FAIL sym_last_rising: got %0d%0d%0d, want 010", q_rise[0], q_rise[1], q_rise[2]);
      end
      checks++;
      if (q_per[2] != 10 || q_to[2] != 0) begin
        errors++;
        $display("FAIL sym_third: got per=%0d to=%0d, want 10 0", q_per[2], q_to[2]);
      end
    end
  endtask

  task automatic test_asymmetric();
    int exp_h[5];
    exp_h = '{3, 7, 3, 7, 3};
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sq_in = 1'b1; run_cycles(3);
      sq_in = 1'b0; run_cycles(7);
    end
    checks++;
    if (q_half.size() != 5) begin
      errors++;
      $display("FAIL asym_valid_count: got %0d, want 5", q_half.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q_half[k] != exp_h[k] || q_pair[k] != (k > 0 ? 1 : 0) || (k > 0 && q_per[k] != 10)) begin
          errors++;
          $display("FAIL asym_sample%0d: got hp=%0d per=%0d pok=%0d, want hp=%0d per=10 pok=%0d",
                   k, q_half[k], q_per[k], q_pair[k], exp_h[k], (k > 0 ? 1 : 0));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int waited;
    do_reset();
    enable = 1'b1;
    sq_in = 1'b1; run_cycles(4);
    sq_in = 1'b0; run_cycles(4);
    sq_in = 1'b1; run_cycles(4);
    checks++;
    if (pok4 !== 1'b1 || hp4 !== 4'd4 || to4 !== 1'b0) begin
      errors++;
      $display("FAIL to_pre: got pok=%0b hp=%0d to=%0b, want 1 4 0", pok4, hp4, to4);
    end
    waited = 0;
    while (to4 !== 1'b1 && waited < 40) begin
      run_cycles(1);
      waited++;
    end
    checks++;
    if (to4 !== 1'b1) begin
      errors++;
      $display("FAIL to_assert: timeout stayed %0b after %0d cycles, want 1", to4, waited);
    end
    checks++;
    if (pok4 !== 1'b0 || hp4 !== 4'd4 || waited < 10) begin
      errors++;
      $display("FAIL to_state: got pok=%0b hp=%0d waited=%0d, want pok=0 hp=4 waited>=10",
               pok4, hp4, waited);
    end
    clear_q();
    sq_in = 1'b0; run_cycles(4);
    sq_in = 1'b1; run_cycles(6);
    checks++;
    if (q4_half.size() != 1) begin
      errors++;
      $display("FAIL to_recover_count: got %0d valids, want 1", q4_half.size());
    end else begin
      checks++;
      if (q4_half[0] != 4 || q4_to[0] != 0 || q4_div[0] != 6) begin
        errors++;
        $display("FAIL to_recover: got hp=%0d to=%0d div=%0d, want 4 0 6", q4_half[0], q4_to[0], q4_div[0]);
      end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    sq_in = 1'b1; run_cycles(5);
    sq_in = 1'b0; run_cycles(5);
    sq_in = 1'b1; run_cycles(5);
    checks++;
    if (q_half.size() != 2 || pok !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre: got %0d valids pok=%0b, want 2 1", q_half.size(), pok);
    end
    clear_q();
    sq_in = 1'b0; enable = 1'b0;
    run_cycles(10);
    checks++;
    if (q_half.size() != 0 || hp !== 16'd5 || per !== 17'd10 || pok !== 1'b0 || div !== 16'd8) begin
      errors++;
      $display("FAIL drop_hold: got %0d valids hp=%0d per=%0d pok=%0b div=%0d, want 0 5 10 0 8",
               q_half.size(), hp, per, pok, div);
    end
    enable = 1'b1;
    sq_in = 1'b1; run_cycles(5);
    sq_in = 1'b0; run_cycles(6);
    checks++;
    if (q_half.size() != 1) begin
      errors++;
      $display("FAIL reenable_count: got %0d valids, want 1", q_half.size());
    end else begin
      checks++;
      if (q_half[0] != 5 || q_pair[0] != 0) begin
        errors++;
        $display("FAIL reenable_sample: got hp=%0d pok=%0d, want 5 0", q_half[0], q_pair[0]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    enable = 1'b1;
    sq_in = 1'b1; run_cycles(5);
    sq_in = 1'b0; run_cycles(5);
    checks++;
    if (hp !== 16'd5) begin
      errors++;
      $display("FAIL inflight_pre: got hp=%0d, want 5", hp);
    end
    clear_q();
    sq_in = 1'b1; run_cycles(2);
    reset = 1'b1; run_cycles(2);
    reset = 1'b0; run_cycles(6);
    checks++;
    if (q_half.size() != 0) begin
      errors++;
      $display("FAIL inflight_valid: got %0d valids, want 0", q_half.size());
    end
    checks++;
    if ({hp, per, div, lr, vld, pok, to} !== '0) begin
      errors++;
      $display("FAIL inflight_outputs: got hp=%0d per=%0d div=%0d lr=%0b pok=%0b to=%0b, want all 0",
               hp, per, div, lr, pok, to);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sq_in = 1'b0;
    test_reset();
    test_symmetric();
    test_asymmetric();
    test_timeout();
    test_enable_drop();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
